vx_lsu_mem_sched: RTL and testbench



---
 rtl/vx_lsu_mem_sched_if.sv | 66 ++++++
 rtl/vx_lsu_mem_sched.sv | 187 ++++++++++++++++++
 tb/tb_vx_lsu_mem_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_lsu_mem_sched_if.sv
// Bus bundle between the LSU block requesters, the memory scheduler and the
// memory unit. The scheduler uses the slave view; the requester/memory side
// (or a testbench standing in for it) uses the master view.
interface vx_lsu_mem_sched_if #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
);
  localparam int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  // Requester-side request bus, one slot per requester
  logic [NUM_REQS-1:0]                      in_req_valid;
  logic [NUM_REQS-1:0]                      in_req_rw;
  logic [NUM_REQS*NUM_LANES-1:0]            in_req_mask;
  logic [NUM_REQS*NUM_LANES*ADDR_WIDTH-1:0] in_req_addr;
  logic [NUM_REQS*NUM_LANES*DATA_WIDTH-1:0] in_req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]            in_req_tag;
  logic [NUM_REQS-1:0]                      in_req_ready;

  // Requester-side response bus: per-requester valid/ready, shared payload
  logic [NUM_REQS-1:0]                      in_rsp_valid;
  logic [NUM_LANES-1:0]                     in_rsp_mask;
  logic [NUM_LANES*DATA_WIDTH-1:0]          in_rsp_data;
  logic [TAG_WIDTH-1:0]                     in_rsp_tag;
  logic [NUM_REQS-1:0]                      in_rsp_ready;

  // Memory-side request bus
  logic                                     out_req_valid;
  logic                                     out_req_rw;
  logic [NUM_LANES-1:0]                     out_req_mask;
  logic [NUM_LANES*ADDR_WIDTH-1:0]          out_req_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0]          out_req_data;
  logic [TAG_WIDTH+IDX_BITS-1:0]            out_req_tag;
  logic                                     out_req_ready;

  // Memory-side response bus
  logic                                     out_rsp_valid;
  logic [NUM_LANES-1:0]                     out_rsp_mask;
  logic [NUM_LANES*DATA_WIDTH-1:0]          out_rsp_data;
  logic [TAG_WIDTH+IDX_BITS-1:0]            out_rsp_tag;
  logic                                     out_rsp_ready;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_mask, in_req_addr, in_req_data, in_req_tag,
    output in_req_ready,
    output in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag,
    input  in_rsp_ready,
    output out_req_valid, out_req_rw, out_req_mask, out_req_addr, out_req_data, out_req_tag,
    input  out_req_ready,
    input  out_rsp_valid, out_rsp_mask, out_rsp_data, out_rsp_tag,
    output out_rsp_ready
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_mask, in_req_addr, in_req_data, in_req_tag,
    input  in_req_ready,
    input  in_rsp_valid, in_rsp_mask, in_rsp_data, in_rsp_tag,
    output in_rsp_ready,
    input  out_req_valid, out_req_rw, out_req_mask, out_req_addr, out_req_data, out_req_tag,
    output out_req_ready,
    output out_rsp_valid, out_rsp_mask, out_rsp_data, out_rsp_tag,
    input  out_rsp_ready
  );
endinterface

// File: rtl/vx_lsu_mem_sched.sv
// LSU memory scheduler: round-robin shares one memory port among NUM_REQS
// LSU blocks. Requests pass through a one-entry elastic buffer with the
// requester index prepended to the tag; responses are routed back
// combinationally by that index. Each requester is limited to MAX_PENDING
// outstanding reads so no block can hog the memory unit's response slots.
module vx_lsu_mem_sched #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_LANES   = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                reset,
  vx_lsu_mem_sched_if.slave   bus,
  output logic                pending_any
);

  localparam int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNT_W    = $clog2(MAX_PENDING + 1);
  localparam int OTAG_W   = TAG_WIDTH + IDX_BITS;

  // Advance an index by off positions, wrapping modulo NUM_REQS.
  function automatic logic [IDX_BITS-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQS) s = s - NUM_REQS;
    return IDX_BITS'(s);
  endfunction

  logic [IDX_BITS-1:0] rr_ptr;
  logic [CNT_W-1:0]    pend_cnt [NUM_REQS];

  logic [NUM_REQS-1:0] elig;
  logic                grant_vld;
  logic [IDX_BITS-1:0] grant_idx;
  logic                buf_ready;
  logic                acc;
  logic [NUM_REQS-1:0] rd_inc;

  logic [IDX_BITS-1:0] rsp_idx;
  logic                rsp_idx_ok;
  logic [NUM_REQS-1:0] rsp_vld;
  logic                rsp_rdy;
  logic [NUM_REQS-1:0] rsp_dec;

  // Output buffer (stage p1 holds the request presented to memory)
  logic                             req_vld_p1;
  logic                             req_rw_p1;
  logic [NUM_LANES-1:0]             req_mask_p1;
  logic [NUM_LANES*ADDR_WIDTH-1:0]  req_addr_p1;
  logic [NUM_LANES*DATA_WIDTH-1:0]  req_data_p1;
  logic [OTAG_W-1:0]                req_tag_p1;

  // A requester competes when it has a request and, for reads, a free pending slot.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = bus.in_req_valid[i] &&
                (bus.in_req_rw[i] || (pend_cnt[i] < CNT_W'(MAX_PENDING)));
    end
  end

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!grant_vld && elig[wrap_idx(32'(rr_ptr), k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(32'(rr_ptr), k);
      end
    end
  end

  // The buffer can take a new request when empty or when it drains this cycle.
  assign buf_ready = !req_vld_p1 || bus.out_req_ready;
  assign acc       = grant_vld && buf_ready && !reset;

  // Ready goes only to the granted requester; read accepts bump its counter.
  always_comb begin
    bus.in_req_ready = '0;
    rd_inc           = '0;
    if (acc) begin
      bus.in_req_ready[grant_idx] = 1'b1;
      rd_inc[grant_idx]           = !bus.in_req_rw[grant_idx];
    end
  end

  // Stage boundary p0 -> p1: capture the granted request with its index in the tag MSBs.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_vld_p1  <= 1'b0;
      req_rw_p1   <= 1'b0;
      req_mask_p1 <= '0;
      req_addr_p1 <= '0;
      req_data_p1 <= '0;
      req_tag_p1  <= '0;
    end else if (buf_ready) begin
      req_vld_p1 <= acc;
      if (acc) begin
        req_rw_p1   <= bus.in_req_rw[grant_idx];
        req_mask_p1 <= bus.in_req_mask[grant_idx*NUM_LANES +: NUM_LANES];
        req_addr_p1 <= bus.in_req_addr[grant_idx*NUM_LANES*ADDR_WIDTH +: NUM_LANES*ADDR_WIDTH];
        req_data_p1 <= bus.in_req_data[grant_idx*NUM_LANES*DATA_WIDTH +: NUM_LANES*DATA_WIDTH];
        req_tag_p1  <= {grant_idx, bus.in_req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH]};
      end
    end
  end

  assign bus.out_req_valid = req_vld_p1;
  assign bus.out_req_rw    = req_rw_p1;
  assign bus.out_req_mask  = req_mask_p1;
  assign bus.out_req_addr  = req_addr_p1;
  assign bus.out_req_data  = req_data_p1;
  assign bus.out_req_tag   = req_tag_p1;

  // Pointer moves just past the requester that was actually accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (acc) begin
      rr_ptr <= wrap_idx(32'(grant_idx), 1);
    end
  end

  // Response routing by the index held in the tag MSBs; bad indices are sunk.
  assign rsp_idx    = bus.out_rsp_tag[OTAG_W-1 -: IDX_BITS];
  assign rsp_idx_ok = (32'(rsp_idx) < 32'(NUM_REQS));

  // Decode the response index into a one-hot valid and pick that requester's ready.
  always_comb begin
    rsp_vld = '0;
    rsp_rdy = 1'b1;
    rsp_dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx_ok && (rsp_idx == IDX_BITS'(i))) begin
        rsp_vld[i] = bus.out_rsp_valid;
        rsp_rdy    = bus.in_rsp_ready[i];
        rsp_dec[i] = bus.out_rsp_valid && bus.in_rsp_ready[i];
      end
    end
  end

  assign bus.in_rsp_valid  = rsp_vld;
  assign bus.out_rsp_ready = rsp_rdy;
  assign bus.in_rsp_mask   = bus.out_rsp_mask;
  assign bus.in_rsp_data   = bus.out_rsp_data;
  assign bus.in_rsp_tag    = bus.out_rsp_tag[TAG_WIDTH-1:0];

  // Outstanding-read counters: +1 on read accept, -1 on response, both cancel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (reset) begin
        pend_cnt[i] <= '0;
      end else if (rd_inc[i] && !rsp_dec[i]) begin
        pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
      end else if (rsp_dec[i] && !rd_inc[i] && (pend_cnt[i] != '0)) begin
        pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Any requester with reads still in flight.
  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pend_cnt[i] != '0) pending_any = 1'b1;
    end
  end

  // Flag responses that carry an unknown index or have no matching outstanding read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.out_rsp_valid) begin
        assert (rsp_idx_ok);
      end
      for (int i = 0; i < NUM_REQS; i++) begin
        if (rsp_dec[i] && !rd_inc[i]) begin
          assert (pend_cnt[i] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_lsu_mem_sched.sv
// Testbench for vx_lsu_mem_sched: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the scheduler's rules.
module tb_vx_lsu_mem_sched;

  localparam int NR  = 4;
  localparam int NL  = 4;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int MP  = 8;
  localparam int IB  = (NR > 1) ? $clog2(NR) : 1;
  localparam int OTW = TW + IB;
  localparam int PKT_W = 1 + NL + NL*AW + NL*DW + OTW;

  logic clk = 1'b0;
  logic reset;
  logic pending_any;

  always #5 clk = ~clk;

  vx_lsu_mem_sched_if #(.NUM_REQS(NR), .NUM_LANES(NL), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  vx_lsu_mem_sched #(.NUM_REQS(NR), .NUM_LANES(NL), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pending_any(pending_any));

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int             m_pend [NR];
  int             m_ptr;
  bit             m_bv;
  logic [PKT_W-1:0] m_bpkt;

  // Per-tick expected / observed values
  int exp_g, acc_g, ridx;
  logic can_acc;
  logic [NR-1:0] exp_rdy, obs_rdy, exp_rspv, obs_rspv;
  logic exp_ovld, obs_ovld, exp_rrdy, obs_rrdy, exp_pany, obs_pany;
  logic [PKT_W-1:0] exp_pkt, obs_pkt, acc_pkt;
  logic [TW-1:0] exp_rtag, obs_rtag;
  logic [NL*DW-1:0] obs_rdata;
  int obs_grants[$];

  function automatic logic [PKT_W-1:0] in_pkt(int g);
    return {bus.in_req_rw[g], bus.in_req_mask[g*NL +: NL], bus.in_req_addr[g*NL*AW +: NL*AW],
            bus.in_req_data[g*NL*DW +: NL*DW], IB'(g), bus.in_req_tag[g*TW +: TW]};
  endfunction

  function automatic logic [PKT_W-1:0] out_pkt();
    return {bus.out_req_rw, bus.out_req_mask, bus.out_req_addr, bus.out_req_data, bus.out_req_tag};
  endfunction

  // Round-robin rule: among eligible requesters, the one closest at/after the pointer.
  function automatic int model_grant();
    int best = -1;
    int bestd = NR;
    for (int i = 0; i < NR; i++) begin
      if (bus.in_req_valid[i] && (bus.in_req_rw[i] || m_pend[i] < MP)) begin
        int d = (i - m_ptr + NR) % NR;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_pend[i] = 0;
    m_ptr = 0; m_bv = 0; m_bpkt = '0;
  endtask

  task automatic idle_inputs();
    bus.in_req_valid = '0; bus.in_req_rw = '0; bus.in_req_mask = '0;
    bus.in_req_addr = '0; bus.in_req_data = '0; bus.in_req_tag = '0;
    bus.in_rsp_ready = '1; bus.out_req_ready = 1'b1;
    bus.out_rsp_valid = 1'b0; bus.out_rsp_mask = '0; bus.out_rsp_data = '0; bus.out_rsp_tag = '0;
  endtask

  task automatic set_req(int i, logic rw, logic [TW-1:0] tag);
    bus.in_req_valid[i] = 1'b1;
    bus.in_req_rw[i] = rw;
    bus.in_req_tag[i*TW +: TW] = tag;
    for (int b = 0; b < NL; b++) bus.in_req_mask[i*NL + b] = 1'($urandom_range(0, 1));
    for (int b = 0; b < NL*AW; b++) bus.in_req_addr[i*NL*AW + b] = 1'($urandom_range(0, 1));
    for (int b = 0; b < NL*DW; b++) bus.in_req_data[i*NL*DW + b] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_rsp(int j, logic [TW-1:0] tag);
    bus.out_rsp_valid = 1'b1;
    bus.out_rsp_tag = {IB'(j), tag};
    for (int b = 0; b < NL; b++) bus.out_rsp_mask[b] = 1'($urandom_range(0, 1));
    for (int b = 0; b < NL*DW; b++) bus.out_rsp_data[b] = 1'($urandom_range(0, 1));
  endtask

  // One clock: sample mid-cycle, predict from the model, then advance the model.
  task automatic tick();
    @(negedge clk);
    exp_g   = model_grant();
    can_acc = !reset && (!m_bv || bus.out_req_ready);
    exp_rdy = '0;
    if (exp_g >= 0 && can_acc) exp_rdy[exp_g] = 1'b1;
    acc_g   = (exp_g >= 0 && can_acc) ? exp_g : -1;
    acc_pkt = (acc_g >= 0) ? in_pkt(acc_g) : '0;
    exp_ovld = m_bv; exp_pkt = m_bpkt;
    ridx = int'(bus.out_rsp_tag[OTW-1 -: IB]);
    exp_rspv = '0;
    if (bus.out_rsp_valid && ridx < NR) exp_rspv[ridx] = 1'b1;
    exp_rrdy = (ridx < NR) ? bus.in_rsp_ready[ridx] : 1'b1;
    exp_rtag = bus.out_rsp_tag[TW-1:0];
    exp_pany = 1'b0;
    for (int i = 0; i < NR; i++) if (m_pend[i] > 0) exp_pany = 1'b1;
    obs_rdy = bus.in_req_ready; obs_ovld = bus.out_req_valid; obs_pkt = out_pkt();
    obs_rspv = bus.in_rsp_valid; obs_rrdy = bus.out_rsp_ready; obs_rtag = bus.in_rsp_tag;
    obs_rdata = bus.in_rsp_data; obs_pany = pending_any;
    for (int i = 0; i < NR; i++) if (obs_rdy[i]) obs_grants.push_back(i);
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (exp_rspv != '0 && exp_rrdy && m_pend[ridx] > 0) m_pend[ridx]--;
      if (acc_g >= 0) begin
        m_bv = 1; m_bpkt = acc_pkt; m_ptr = (acc_g + 1) % NR;
        if (!acc_pkt[PKT_W-1]) m_pend[acc_g]++;
      end else if (can_acc) begin
        m_bv = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, TW'(i));
    drive_rsp(1, 8'hA5);
    tick(); tick();
    checks++; if (obs_rdy !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", obs_rdy); end
    checks++; if (obs_ovld !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", obs_ovld); end
    checks++; if (obs_pkt !== '0) begin errors++; $display("FAIL reset_buffer: got %h want 0", obs_pkt); end
    checks++; if (obs_pany !== 1'b0) begin errors++; $display("FAIL reset_pending_any: got %b want 0", obs_pany); end
    checks++; if (obs_rspv !== 4'b0010) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0010", obs_rspv); end
    checks++; if (obs_rtag !== 8'hA5) begin errors++; $display("FAIL reset_rsp_tag: got %h want a5", obs_rtag); end
    checks++; if (dut.rr_ptr !== '0) begin errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    logic [PKT_W-1:0] want;
    do_reset();
    set_req(2, 1'b0, 8'h15);
    want = in_pkt(2);
    tick();
    checks++; if (obs_rdy !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", obs_rdy); end
    bus.in_req_valid = '0;
    tick();
    checks++; if (obs_ovld !== 1'b1) begin errors++; $display("FAIL single_latency: got %b want 1", obs_ovld); end
    checks++; if (obs_pkt[OTW-1:0] !== {2'd2, 8'h15}) begin errors++; $display("FAIL single_tag: got %h want 215", obs_pkt[OTW-1:0]); end
    checks++; if (obs_pkt !== want) begin errors++; $display("FAIL single_payload: got %h want %h", obs_pkt, want); end
    checks++; if (obs_pany !== 1'b1) begin errors++; $display("FAIL single_pending: got %b want 1", obs_pany); end
    drive_rsp(2, 8'h15);
    tick();
    checks++; if (obs_rspv !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid: got %b want 0100", obs_rspv); end
    checks++; if (obs_rtag !== 8'h15) begin errors++; $display("FAIL single_rsp_tag: got %h want 15", obs_rtag); end
    checks++; if (obs_rdata !== bus.out_rsp_data) begin errors++; $display("FAIL single_rsp_data: got %h want %h", obs_rdata, bus.out_rsp_data); end
    checks++; if (obs_rrdy !== 1'b1) begin errors++; $display("FAIL single_rsp_ready: got %b want 1", obs_rrdy); end
    checks++; if (obs_ovld !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", obs_ovld); end
    bus.out_rsp_valid = 1'b0;
    tick();
    checks++; if (dut.pend_cnt[2] !== 4'd0) begin errors++; $display("FAIL single_cnt: got %0d want 0", dut.pend_cnt[2]); end
    checks++; if (obs_pany !== 1'b0) begin errors++; $display("FAIL single_pending_clear: got %b want 0", obs_pany); end
  endtask

  task automatic test_fairness();
    int cyc = 0;
    int bad_order = 0;
    int cnt [NR];
    do_reset();
    obs_grants.delete();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, TW'(8'h40 + i));
    while (obs_grants.size() < 100 && cyc < 400) begin
      bus.out_rsp_valid = 1'b0;
      for (int j = 0; j < NR; j++) begin
        if (!bus.out_rsp_valid && m_pend[j] > 0) drive_rsp(j, TW'(j));
      end
      tick();
      cyc++;
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL fair_ready: got %b want %b", obs_rdy, exp_rdy); end
    end
    checks++; if (obs_grants.size() < 100) begin errors++; $display("FAIL fair_timeout: got %0d grants want 100", obs_grants.size()); end
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int k = 0; k < 100 && k < obs_grants.size(); k++) begin
      if (obs_grants[k] != k % NR) bad_order++;
      cnt[obs_grants[k]]++;
    end
    checks++; if (bad_order != 0) begin errors++; $display("FAIL fair_order: got %0d out-of-order grants want 0", bad_order); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (cnt[i] != 25) begin errors++; $display("FAIL fair_share%0d: got %0d want 25", i, cnt[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_pending_cap();
    int acc1 = 0;
    do_reset();
    set_req(1, 1'b0, 8'h21);
    for (int c = 0; c < 12; c++) begin tick(); if (obs_rdy[1]) acc1++; end
    checks++; if (acc1 != MP) begin errors++; $display("FAIL cap_accepts: got %0d want %0d", acc1, MP); end
    checks++; if (obs_rdy !== '0) begin errors++; $display("FAIL cap_stall: got %b want 0000", obs_rdy); end
    checks++; if (obs_pany !== 1'b1) begin errors++; $display("FAIL cap_pending: got %b want 1", obs_pany); end
    set_req(3, 1'b0, 8'h31);
    tick();
    checks++; if (obs_rdy !== 4'b1000) begin errors++; $display("FAIL cap_other_granted: got %b want 1000", obs_rdy); end
    bus.in_req_valid[3] = 1'b0;
    drive_rsp(1, 8'h21);
    tick();
    checks++; if (obs_rspv !== 4'b0010) begin errors++; $display("FAIL cap_rsp_valid: got %b want 0010", obs_rspv); end
    checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL cap_rsp_cycle_ready: got %b want %b", obs_rdy, exp_rdy); end
    bus.out_rsp_valid = 1'b0;
    acc1 = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (obs_rdy[1]) acc1++; end
    checks++; if (acc1 != 1) begin errors++; $display("FAIL cap_refill: got %0d want 1", acc1); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0] sb[$];
    logic [PKT_W-1:0] first;
    int accs = 0;
    do_reset();
    bus.out_req_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, TW'(8'h60 + i));
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int i = 0; i < NR; i++) if (obs_rdy[i]) begin accs++; sb.push_back(in_pkt(i)); end
      if (c > 0) begin
        checks++;
        if (obs_ovld !== 1'b1 || sb.size() == 0 || obs_pkt !== sb[0]) begin
          errors++; $display("FAIL bp_hold: got v=%b %h", obs_ovld, obs_pkt);
        end
      end
    end
    checks++; if (accs != 1) begin errors++; $display("FAIL bp_accepts: got %0d want 1", accs); end
    first = (sb.size() > 0) ? sb[0] : '0;
    checks++; if (first[OTW-1:0] !== {2'd0, 8'h60}) begin errors++; $display("FAIL bp_first_tag: got %h want 060", first[OTW-1:0]); end
    bus.out_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_ovld !== 1'b1 || sb.size() == 0 || obs_pkt !== sb[0]) begin
        errors++; $display("FAIL bp_drain%0d: got v=%b %h", c, obs_ovld, obs_pkt);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      checks++; if (obs_rdy === '0) begin errors++; $display("FAIL bp_b2b_accept%0d: got %b want one-hot", c, obs_rdy); end
      for (int i = 0; i < NR; i++) if (obs_rdy[i]) sb.push_back(in_pkt(i));
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < NR; j++) if (!bus.out_rsp_valid && m_pend[j] > 0) drive_rsp(j, 8'h00);
      tick();
      bus.out_rsp_valid = 1'b0;
    end
  endtask

  task automatic test_inc_dec();
    do_reset();
    set_req(0, 1'b0, 8'h01);
    tick(); tick(); tick();
    checks++; if (dut.pend_cnt[0] !== 4'd3) begin errors++; $display("FAIL incdec_setup: got %0d want 3", dut.pend_cnt[0]); end
    drive_rsp(0, 8'h01);
    tick();
    checks++; if (obs_rdy !== 4'b0001 || obs_rspv !== 4'b0001) begin errors++; $display("FAIL incdec_both_fire: got rdy=%b rsp=%b want 0001/0001", obs_rdy, obs_rspv); end
    checks++; if (dut.pend_cnt[0] !== 4'd3) begin errors++; $display("FAIL incdec_same: got %0d want 3", dut.pend_cnt[0]); end
    bus.out_rsp_valid = 1'b0;
    set_req(0, 1'b1, 8'h02);
    tick(); tick();
    checks++; if (obs_rdy !== 4'b0001) begin errors++; $display("FAIL incdec_write_accept: got %b want 0001", obs_rdy); end
    bus.in_req_valid = '0;
    tick();
    checks++; if (dut.pend_cnt[0] !== 4'd3) begin errors++; $display("FAIL incdec_write: got %0d want 3", dut.pend_cnt[0]); end
    for (int c = 0; c < 3; c++) begin drive_rsp(0, 8'h01); tick(); end
    bus.out_rsp_valid = 1'b0;
    tick();
    checks++; if (obs_pany !== 1'b0) begin errors++; $display("FAIL incdec_drain: got %b want 0", obs_pany); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b0, 8'h0A);
    tick(); tick(); tick();
    bus.in_req_valid = '0;
    set_req(1, 1'b0, 8'h1B);
    for (int c = 0; c < 5; c++) tick();
    bus.in_req_valid = '0;
    bus.out_req_ready = 1'b0;
    set_req(2, 1'b1, 8'h2C);
    tick();
    checks++;
    if (dut.pend_cnt[0] !== 4'd3 || dut.pend_cnt[1] !== 4'd5 || bus.out_req_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: got %0d/%0d v=%b want 3/5 v=1", dut.pend_cnt[0], dut.pend_cnt[1], bus.out_req_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++; if (bus.out_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_req_valid); end
    checks++; if (dut.pend_cnt[0] !== 4'd0 || dut.pend_cnt[1] !== 4'd0) begin errors++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", dut.pend_cnt[0], dut.pend_cnt[1]); end
    checks++; if (dut.rr_ptr !== '0) begin errors++; $display("FAIL midrst_ptr: got %0d want 0", dut.rr_ptr); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL midrst_pending: got %b want 0", pending_any); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 99) < 60) set_req(i, 1'($urandom_range(0, 3) == 0), TW'($urandom));
        else bus.in_req_valid[i] = 1'b0;
        bus.in_rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      bus.out_req_ready = ($urandom_range(0, 3) != 0);
      bus.out_rsp_valid = 1'b0;
      if ($urandom_range(0, 99) < 60) begin
        int j = int'($urandom_range(0, NR - 1));
        if (m_pend[j] > 0) drive_rsp(j, TW'($urandom));
      end
      tick();
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_rdy, exp_rdy); end
      checks++; if (obs_ovld !== exp_ovld) begin errors++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, obs_ovld, exp_ovld); end
      if (exp_ovld) begin
        checks++; if (obs_pkt !== exp_pkt) begin errors++; $display("FAIL rnd_out_pkt c%0d: got tag %h want %h", c, obs_pkt[OTW-1:0], exp_pkt[OTW-1:0]); end
      end
      checks++; if (obs_rspv !== exp_rspv) begin errors++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, obs_rspv, exp_rspv); end
      checks++; if (obs_rrdy !== exp_rrdy) begin errors++; $display("FAIL rnd_rsp_ready c%0d: got %b want %b", c, obs_rrdy, exp_rrdy); end
      checks++; if (obs_rtag !== exp_rtag) begin errors++; $display("FAIL rnd_rsp_tag c%0d: got %h want %h", c, obs_rtag, exp_rtag); end
      checks++; if (obs_pany !== exp_pany) begin errors++; $display("FAIL rnd_pending c%0d: got %b want %b", c, obs_pany, exp_pany); end
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_fairness();
    test_pending_cap();
    test_back_to_back();
    test_inc_dec();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
